pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage core. Merges load-use hazards, taken-branch redirects,

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/hazard_perf_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: writeback selects, FSM states and the
// per-stage control bundle it drives.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MDU_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } hz_ctrl_t;

    localparam hz_ctrl_t HZ_CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t HZ_CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t HZ_CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t HZ_CTRL_LU     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t HZ_CTRL_MDU    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources from ID/EX/MEM and the stage enables/flushes returned to the pipeline.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_ADDR_WIDTH-1:0] rs1_addr_ID_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_ID_i;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_EX_i;
    wb_sel_e                   WBSel_EX_i;
    logic                      branch_taken_EX_i;
    logic                      dmem_req_MEM_i;
    logic                      dmem_ready_i;
    logic                      mdu_start_EX_i;
    logic                      mdu_done_i;
    logic                      pc_en_o;
    logic                      if_id_en_o;
    logic                      id_ex_en_o;
    logic                      ex_mem_en_o;
    logic                      mem_wb_en_o;
    logic                      flush_if_id_o;
    logic                      flush_id_ex_o;
    logic                      flush_ex_mem_o;

    modport master (
        output rs1_addr_ID_i, rs2_addr_ID_i, rd_addr_EX_i, WBSel_EX_i, branch_taken_EX_i,
               dmem_req_MEM_i, dmem_ready_i, mdu_start_EX_i, mdu_done_i,
        input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               flush_if_id_o, flush_id_ex_o, flush_ex_mem_o
    );

    modport slave (
        input  rs1_addr_ID_i, rs2_addr_ID_i, rd_addr_EX_i, WBSel_EX_i, branch_taken_EX_i,
               dmem_req_MEM_i, dmem_ready_i, mdu_start_EX_i, mdu_done_i,
        output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               flush_if_id_o, flush_id_ex_o, flush_ex_mem_o
    );

endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones, cleared by rst.
module hazard_perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Prioritised stall/flush sequencer: memory freeze > MDU wait > branch redirect > load-use.
// LOAD_USE_BUBBLES must lie in 1..3.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned CNT_WIDTH        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz_if,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    hz_state_e state_q, state_d;
    logic [1:0] bub_q, bub_d;
    hz_ctrl_t  ctrl;
    logic      freeze;
    logic      lu_hit;
    logic      flush_inc;

    assign freeze = hz_if.dmem_req_MEM_i & ~hz_if.dmem_ready_i;
    assign lu_hit = (hz_if.WBSel_EX_i == WB_MEM) && (hz_if.rd_addr_EX_i != '0) &&
                    ((hz_if.rd_addr_EX_i == hz_if.rs1_addr_ID_i) ||
                     (hz_if.rd_addr_EX_i == hz_if.rs2_addr_ID_i));

    always_comb begin
        state_d   = state_q;
        bub_d     = bub_q;
        ctrl      = HZ_CTRL_RUN;
        flush_inc = 1'b0;
        if (freeze) begin
            // Whole pipe frozen; FSM and bubble count hold so pending work resumes afterwards.
            ctrl = HZ_CTRL_FREEZE;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    if (hz_if.mdu_start_EX_i && !hz_if.mdu_done_i) begin
                        ctrl    = HZ_CTRL_MDU;
                        state_d = HZ_MDU_WAIT;
                    end else if (hz_if.branch_taken_EX_i) begin
                        ctrl      = HZ_CTRL_BRANCH;
                        flush_inc = 1'b1;
                    end else if (lu_hit) begin
                        ctrl = HZ_CTRL_LU;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = HZ_LU_STALL;
                            bub_d   = 2'(LOAD_USE_BUBBLES - 1);
                        end
                    end
                end
                HZ_LU_STALL: begin
                    if (hz_if.branch_taken_EX_i) begin
                        ctrl      = HZ_CTRL_BRANCH;
                        flush_inc = 1'b1;
                        state_d   = HZ_RUN;
                        bub_d     = 2'd0;
                    end else begin
                        ctrl  = HZ_CTRL_LU;
                        bub_d = bub_q - 2'd1;
                        if (bub_q == 2'd1) begin
                            state_d = HZ_RUN;
                        end
                    end
                end
                HZ_MDU_WAIT: begin
                    if (hz_if.mdu_done_i) begin
                        state_d = HZ_RUN;
                    end else begin
                        ctrl = HZ_CTRL_MDU;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    bub_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HZ_RUN;
            bub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    assign hz_if.pc_en_o        = ctrl.pc_en;
    assign hz_if.if_id_en_o     = ctrl.if_id_en;
    assign hz_if.id_ex_en_o     = ctrl.id_ex_en;
    assign hz_if.ex_mem_en_o    = ctrl.ex_mem_en;
    assign hz_if.mem_wb_en_o    = ctrl.mem_wb_en;
    assign hz_if.flush_if_id_o  = ctrl.flush_if_id;
    assign hz_if.flush_id_ex_o  = ctrl.flush_id_ex;
    assign hz_if.flush_ex_mem_o = ctrl.flush_ex_mem;

    hazard_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (~ctrl.pc_en),
        .count_o(stall_cnt_o)
    );

    hazard_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (flush_inc),
        .count_o(flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Drives two controller builds (1 bubble/32-bit counters, 3 bubbles/4-bit counters) with the
// same stimulus and compares them every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    logic clk;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    wb_sel_e    wbsel;
    logic       br, dreq, drdy, mstart, mdone;

    pipeline_hazard_ctrl_if if_a ();
    pipeline_hazard_ctrl_if if_b ();

    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    assign if_a.rs1_addr_ID_i = rs1;     assign if_b.rs1_addr_ID_i = rs1;
    assign if_a.rs2_addr_ID_i = rs2;     assign if_b.rs2_addr_ID_i = rs2;
    assign if_a.rd_addr_EX_i = rd;       assign if_b.rd_addr_EX_i = rd;
    assign if_a.WBSel_EX_i = wbsel;      assign if_b.WBSel_EX_i = wbsel;
    assign if_a.branch_taken_EX_i = br;  assign if_b.branch_taken_EX_i = br;
    assign if_a.dmem_req_MEM_i = dreq;   assign if_b.dmem_req_MEM_i = dreq;
    assign if_a.dmem_ready_i = drdy;     assign if_b.dmem_ready_i = drdy;
    assign if_a.mdu_start_EX_i = mstart; assign if_b.mdu_start_EX_i = mstart;
    assign if_a.mdu_done_i = mdone;      assign if_b.mdu_done_i = mdone;

    pipeline_hazard_ctrl #(
        .LOAD_USE_BUBBLES(1),
        .CNT_WIDTH       (32)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .hz_if      (if_a),
        .stall_cnt_o(stall_a),
        .flush_cnt_o(flush_a)
    );

    pipeline_hazard_ctrl #(
        .LOAD_USE_BUBBLES(3),
        .CNT_WIDTH       (4)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .hz_if      (if_b),
        .stall_cnt_o(stall_b),
        .flush_cnt_o(flush_b)
    );

    logic [7:0]  obs_ctrl[2];
    logic [63:0] obs_stall[2];
    logic [63:0] obs_flush[2];
    assign obs_ctrl[0] = {if_a.pc_en_o, if_a.if_id_en_o, if_a.id_ex_en_o, if_a.ex_mem_en_o,
                          if_a.mem_wb_en_o, if_a.flush_if_id_o, if_a.flush_id_ex_o,
                          if_a.flush_ex_mem_o};
    assign obs_ctrl[1] = {if_b.pc_en_o, if_b.if_id_en_o, if_b.id_ex_en_o, if_b.ex_mem_en_o,
                          if_b.mem_wb_en_o, if_b.flush_if_id_o, if_b.flush_id_ex_o,
                          if_b.flush_ex_mem_o};
    assign obs_stall[0] = 64'(stall_a);
    assign obs_stall[1] = 64'(stall_b);
    assign obs_flush[0] = 64'(flush_a);
    assign obs_flush[1] = 64'(flush_b);

    // Expected control words {pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, fl_ex_mem}
    localparam logic [7:0] E_RUN = 8'b11111_000;
    localparam logic [7:0] E_FRZ = 8'b00000_000;
    localparam logic [7:0] E_BR  = 8'b11111_110;
    localparam logic [7:0] E_LU  = 8'b00111_010;
    localparam logic [7:0] E_MDU = 8'b00011_001;

    int     bub_cfg[2] = '{1, 3};
    longint cnt_max[2] = '{64'hFFFF_FFFF, 64'd15};
    int     bub_left[2];
    bit     mdu_busy[2];
    longint m_stall[2];
    longint m_flush[2];
    int     nxt_bub[2];
    bit     nxt_busy[2];
    bit     inc_stall[2];
    bit     inc_flush[2];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            bub_left[d] = 0;
            mdu_busy[d] = 1'b0;
            m_stall[d]  = 0;
            m_flush[d]  = 0;
        end
    endtask

    // Decide this cycle's expected controls from the hazard rules; commit happens at the edge.
    task automatic model_eval(input int d, output logic [7:0] exp);
        bit lu;
        lu = (wbsel == WB_MEM) && (rd != 0) && ((rd == rs1) || (rd == rs2));
        nxt_bub[d]   = bub_left[d];
        nxt_busy[d]  = mdu_busy[d];
        inc_flush[d] = 1'b0;
        if (dreq && !drdy) begin
            exp = E_FRZ;
        end else if (mdu_busy[d]) begin
            exp = mdone ? E_RUN : E_MDU;
            nxt_busy[d] = !mdone;
        end else if (bub_left[d] == 0 && mstart && !mdone) begin
            exp = E_MDU;
            nxt_busy[d] = 1'b1;
        end else if (br) begin
            exp = E_BR;
            nxt_bub[d] = 0;
            inc_flush[d] = 1'b1;
        end else if (bub_left[d] > 0) begin
            exp = E_LU;
            nxt_bub[d] = bub_left[d] - 1;
        end else if (lu) begin
            exp = E_LU;
            nxt_bub[d] = bub_cfg[d] - 1;
        end else begin
            exp = E_RUN;
        end
        inc_stall[d] = !exp[7];
    endtask

    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                model_eval(d, exp);
                check_eq($sformatf("ctrl[%0d]", d), 64'(obs_ctrl[d]), 64'(exp));
                check_eq($sformatf("stall_cnt[%0d]", d), obs_stall[d], m_stall[d]);
                check_eq($sformatf("flush_cnt[%0d]", d), obs_flush[d], m_flush[d]);
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                bub_left[d] = nxt_bub[d];
                mdu_busy[d] = nxt_busy[d];
                if (inc_stall[d] && m_stall[d] < cnt_max[d]) m_stall[d]++;
                if (inc_flush[d] && m_flush[d] < cnt_max[d]) m_flush[d]++;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; wbsel = WB_ALU;
        br = 1'b0; dreq = 1'b0; drdy = 1'b0; mstart = 1'b0; mdone = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        idle();
        wbsel = WB_MEM; rd = r; rs1 = r;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_eq("reset_ctrl_a", 64'(obs_ctrl[0]), 64'(E_RUN));
        check_eq("reset_stall_b", obs_stall[1], 64'd0);
        tick();

        // Load-use on x5, then x0 which must not stall.
        load_use(5'd5); tick();
        idle(); repeat (3) tick();
        load_use(5'd0); tick();
        idle(); tick();

        // Branch resolving together with a load-use hazard.
        load_use(5'd7); br = 1'b1; tick();
        idle(); tick();

        // Memory freeze in the middle of the 3-bubble stall.
        load_use(5'd9); tick();
        idle(); dreq = 1'b1; drdy = 1'b0; repeat (4) tick();
        idle(); repeat (3) tick();

        // Five-cycle MDU op, then one interrupted by reset.
        idle(); mstart = 1'b1; tick();
        idle(); repeat (4) tick();
        mdone = 1'b1; tick();
        idle(); mstart = 1'b1; tick();
        idle(); repeat (2) tick();
        rst = 1'b1; tick();
        idle(); tick();

        // Long freeze drives the 4-bit stall counter into saturation.
        dreq = 1'b1; repeat (20) tick();
        idle(); tick();

        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            rs1    = 5'($urandom_range(0, 3));
            rs2    = 5'($urandom_range(0, 3));
            rd     = 5'($urandom_range(0, 3));
            wbsel  = wb_sel_e'($urandom_range(0, 3));
            br     = ($urandom_range(0, 6) == 0);
            dreq   = ($urandom_range(0, 3) == 0);
            drdy   = ($urandom_range(0, 1) == 0);
            mstart = ($urandom_range(0, 9) == 0);
            mdone  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
